// File: rtl/pixel_writer_pkg.sv
// rtl/pixel_writer_pkg.sv - command codes, word field positions and FSM states for pixel_writer.
package pixel_writer_pkg;

  localparam int COMMAND_MSB = 31;
  localparam int COMMAND_LSB = 24;

  localparam logic [7:0] CMD_PIXEL      = 8'h00;
  localparam logic [7:0] CMD_FRAME_SYNC = 8'h01;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

endpackage

// File: rtl/pixel_writer_strobe_sync.sv
// rtl/pixel_writer_strobe_sync.sv - 2-flop synchroniser with a one-cycle rising-edge pulse.
module strobe_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic pulse_out
);

  logic sync1;
  logic sync2;
  logic delayed;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      delayed <= 1'b0;
    end else begin
      sync1   <= async_in;
      sync2   <= sync1;
      delayed <= sync2;
    end
  end

  assign pulse_out = sync2 & ~delayed;

endmodule

// File: rtl/pixel_writer.sv
// rtl/pixel_writer.sv - decodes SPI words into pixel writes to the back half of a double-buffered frame RAM.
module pixel_writer
  import pixel_writer_pkg::*;
#(
  parameter int BITS_PER_PIXEL = 32,
  parameter int PANEL_WIDTH    = 64,
  parameter int PANEL_HEIGHT   = 32,
  parameter int COLOUR_BITS    = 24,
  parameter int INDEX_BITS     = 11
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [BITS_PER_PIXEL-1:0] spi_data,
  input  logic                      pixel_clk,
  input  logic                      fb_ready,
  output logic                      fb_we,
  output logic [INDEX_BITS:0]       fb_addr,
  output logic [COLOUR_BITS-1:0]    fb_data,
  output logic                      front_buffer,
  output logic                      frame_done,
  output logic                      overrun
);

  localparam logic [INDEX_BITS-1:0] LAST_INDEX = INDEX_BITS'(PANEL_WIDTH * PANEL_HEIGHT - 1);

  state_t                state;
  logic [INDEX_BITS-1:0] pixel_index;
  logic                  strobe;
  logic [7:0]            command;

  strobe_sync u_strobe_sync (
    .clk       (clk),
    .reset_n   (reset_n),
    .async_in  (pixel_clk),
    .pulse_out (strobe)
  );

  // spi_data is still stable when the synchronised strobe arrives, so it is decoded directly.
  assign command = spi_data[COMMAND_MSB:COMMAND_LSB];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      fb_we        <= 1'b0;
      fb_addr      <= '0;
      fb_data      <= '0;
      front_buffer <= 1'b0;
      frame_done   <= 1'b0;
      overrun      <= 1'b0;
      pixel_index  <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (strobe) begin
            if (command == CMD_PIXEL) begin
              fb_we   <= 1'b1;
              fb_addr <= {~front_buffer, pixel_index};
              fb_data <= spi_data[COLOUR_BITS-1:0];
              state   <= WRITE;
            end else if (command == CMD_FRAME_SYNC) begin
              pixel_index <= '0;
            end
          end
        end
        WRITE: begin
          // A strobe here, including on the completing edge, loses its word.
          if (strobe) overrun <= 1'b1;
          if (fb_ready) begin
            fb_we <= 1'b0;
            state <= IDLE;
            if (pixel_index == LAST_INDEX) begin
              pixel_index  <= '0;
              front_buffer <= ~front_buffer;
              frame_done   <= 1'b1;
            end else begin
              pixel_index <= pixel_index + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_writer.sv
// tb/tb_pixel_writer.sv - self-checking bench for pixel_writer against a frame-level reference model.
module tb_pixel_writer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] spi_data = '0;
  logic        pixel_clk = 1'b0;
  logic        fb_ready = 1'b1;
  logic        fb_we;
  logic [11:0] fb_addr;
  logic [23:0] fb_data;
  logic        front_buffer;
  logic        frame_done;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  logic [35:0] obs_q[$];
  logic [35:0] exp_q[$];
  int          fd_count = 0;
  int          m_idx = 0;
  logic        m_front = 1'b0;

  pixel_writer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .spi_data     (spi_data),
    .pixel_clk    (pixel_clk),
    .fb_ready     (fb_ready),
    .fb_we        (fb_we),
    .fb_addr      (fb_addr),
    .fb_data      (fb_data),
    .front_buffer (front_buffer),
    .frame_done   (frame_done),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  // A write completes on the next rising edge when both fb_we and fb_ready are high.
  always @(negedge clk) begin
    if (reset_n) begin
      if (fb_we && fb_ready) obs_q.push_back({fb_addr, fb_data});
      if (frame_done) fd_count++;
    end
  end

  function automatic void model_word(input logic [31:0] w);
    if (w[31:24] == 8'h00) begin
      exp_q.push_back({~m_front, 11'(m_idx), w[23:0]});
      if (m_idx == 64 * 32 - 1) begin
        m_idx   = 0;
        m_front = ~m_front;
      end else begin
        m_idx++;
      end
    end else if (w[31:24] == 8'h01) begin
      m_idx = 0;
    end
  endfunction

  task automatic do_reset();
    reset_n   = 1'b0;
    pixel_clk = 1'b0;
    fb_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    obs_q.delete();
    exp_q.delete();
    fd_count = 0;
    m_idx    = 0;
    m_front  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w);
    @(posedge clk);
    #1;
    spi_data  = w;
    pixel_clk = 1'b1;
    repeat (4) @(posedge clk);
    #1 pixel_clk = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({fb_we, fb_addr, fb_data, front_buffer, frame_done, overrun} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got we=%0b addr=%h data=%h front=%0b fd=%0b ovr=%0b want all zero",
               fb_we, fb_addr, fb_data, front_buffer, frame_done, overrun);
    end
  endtask

  task automatic test_first_pixel();
    int n;
    do_reset();
    @(posedge clk);
    #1;
    spi_data  = 32'h0011_2233;
    pixel_clk = 1'b1;
    model_word(spi_data);
    n = 0;
    while (!fb_we && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n < 3 || n > 4) begin
      errors++;
      $display("FAIL latency got %0d edges want 3..4", n);
    end
    checks++;
    if (fb_addr !== 12'h800 || fb_data !== 24'h112233) begin
      errors++;
      $display("FAIL first_write got addr=%h data=%h want 800 112233", fb_addr, fb_data);
    end
    repeat (3) @(posedge clk);
    #1 pixel_clk = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    send_word(32'h0044_5566);
    model_word(32'h0044_5566);
    checks++;
    if (obs_q.size() != exp_q.size() || front_buffer !== 1'b0) begin
      errors++;
      $display("FAIL first_count got %0d writes front=%0b want %0d front=0", obs_q.size(), front_buffer, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL first_write_%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_frame_sync();
    logic [31:0] seq [4] = '{32'h00AA_AAAA, 32'h00BB_BBBB, 32'h0100_0000, 32'h00CC_CCCC};
    do_reset();
    foreach (seq[i]) begin
      send_word(seq[i]);
      model_word(seq[i]);
    end
    checks++;
    if (obs_q.size() != 3) begin
      errors++;
      $display("FAIL sync_count got %0d want 3", obs_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL sync_write_%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (fd_count != 0 || front_buffer !== 1'b0) begin
      errors++;
      $display("FAIL sync_no_swap got fd=%0d front=%0b want 0 0", fd_count, front_buffer);
    end
  endtask

  task automatic test_full_frame();
    do_reset();
    for (int i = 0; i < 2048; i++) begin
      send_word({8'h00, 24'(i)});
      model_word({8'h00, 24'(i)});
    end
    checks++;
    if (fd_count != 1 || front_buffer !== 1'b1) begin
      errors++;
      $display("FAIL frame_swap got fd=%0d front=%0b want 1 1", fd_count, front_buffer);
    end
    send_word(32'h0012_3456);
    model_word(32'h0012_3456);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL frame_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL frame_write_%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_overrun();
    do_reset();
    fb_ready = 1'b0;
    send_word(32'h0012_3456);
    model_word(32'h0012_3456);
    checks++;
    if (fb_we !== 1'b1 || fb_addr !== 12'h800 || fb_data !== 24'h123456 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL stall_hold got we=%0b addr=%h data=%h ovr=%0b want 1 800 123456 0", fb_we, fb_addr, fb_data, overrun);
    end
    send_word(32'h0099_9999);
    checks++;
    if (fb_we !== 1'b1 || fb_addr !== 12'h800 || fb_data !== 24'h123456 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_hold got we=%0b addr=%h data=%h ovr=%0b want 1 800 123456 1", fb_we, fb_addr, fb_data, overrun);
    end
    fb_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    send_word(32'h0000_0001);
    model_word(32'h0000_0001);
    checks++;
    if (obs_q.size() != exp_q.size() || overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_count got %0d writes ovr=%0b want %0d ovr=1", obs_q.size(), overrun, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL overrun_write_%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_ignored();
    do_reset();
    send_word(32'hdead_beef);
    send_word(32'hcabb_a6e0);
    checks++;
    if (obs_q.size() != 0 || fb_we !== 1'b0) begin
      errors++;
      $display("FAIL ignored_words got %0d writes we=%0b want 0 0", obs_q.size(), fb_we);
    end
    send_word(32'h0000_0000);
    checks++;
    if (obs_q.size() != 1 || (obs_q.size() == 1 && obs_q[0] !== {12'h800, 24'h000000})) begin
      errors++;
      $display("FAIL ignored_then_pixel got %0d writes first=%h want 1 800000000", obs_q.size(),
               obs_q.size() > 0 ? obs_q[0] : 36'h0);
    end
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    fb_ready = 1'b0;
    send_word(32'h0077_8899);
    send_word(32'h0011_1111);
    checks++;
    if (fb_we !== 1'b1 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset got we=%0b ovr=%0b want 1 1", fb_we, overrun);
    end
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    checks++;
    if ({fb_we, fb_addr, fb_data, front_buffer, frame_done, overrun} !== '0) begin
      errors++;
      $display("FAIL async_reset got we=%0b addr=%h data=%h front=%0b fd=%0b ovr=%0b want all zero",
               fb_we, fb_addr, fb_data, front_buffer, frame_done, overrun);
    end
    do_reset();
    send_word(32'h00AB_CDEF);
    checks++;
    if (obs_q.size() != 1 || (obs_q.size() == 1 && obs_q[0] !== {12'h800, 24'hABCDEF})) begin
      errors++;
      $display("FAIL after_reset got %0d writes first=%h want 1 800abcdef", obs_q.size(),
               obs_q.size() > 0 ? obs_q[0] : 36'h0);
    end
  endtask

  task automatic test_random();
    logic [31:0] w;
    int          r;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      w = $urandom;
      if (r < 7) w[31:24] = 8'h00;
      else if (r == 7) w[31:24] = 8'h01;
      else if (w[31:24] < 8'h02) w[31:24] = 8'h80;
      send_word(w);
      model_word(w);
    end
    checks++;
    if (obs_q.size() != exp_q.size() || front_buffer !== m_front || overrun !== 1'b0) begin
      errors++;
      $display("FAIL random_count got %0d writes front=%0b ovr=%0b want %0d front=%0b ovr=0",
               obs_q.size(), front_buffer, overrun, exp_q.size(), m_front);
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL random_write_%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_pixel();
    test_frame_sync();
    test_overrun();
    test_ignored();
    test_reset_mid_write();
    test_random();
    test_full_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
